// File: rtl/nav_motion_sequencer.sv
// Jump/speed sequencer driving the shared mode, pos_mode and jump_position selects
// of the per-axis position datapaths. All outputs are registered.
module nav_motion_sequencer #(
  parameter int unsigned k               = 16,
  parameter int unsigned CHARGE_CYCLES   = 4,
  parameter int unsigned COOLDOWN_CYCLES = 3,
  parameter int unsigned CNT_W           = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd,
  input  logic [k-1:0] jump_target,
  input  logic         abort,
  output logic [3:0]   mode,
  output logic [3:0]   pos_mode,
  output logic [k-1:0] jump_position,
  output logic         busy,
  output logic         jump_done,
  output logic         cmd_err
);

  localparam logic [3:0] ModeStop    = 4'b0001;
  localparam logic [3:0] ModeAttack  = 4'b0010;
  localparam logic [3:0] ModeDefense = 4'b0100;
  localparam logic [3:0] ModeStealth = 4'b1000;
  localparam logic [3:0] PosZero     = 4'b0001;
  localparam logic [3:0] PosSub      = 4'b0010;
  localparam logic [3:0] PosJump     = 4'b0100;

  localparam logic [CNT_W-1:0] CntZero    = '0;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ChargeInit = CNT_W'(CHARGE_CYCLES);
  localparam logic [CNT_W-1:0] CoolInit   = CNT_W'(COOLDOWN_CYCLES);

  localparam logic [2:0] OpHalt    = 3'd0;
  localparam logic [2:0] OpAttack  = 3'd1;
  localparam logic [2:0] OpDefense = 3'd2;
  localparam logic [2:0] OpStealth = 3'd3;
  localparam logic [2:0] OpJump    = 3'd4;
  localparam logic [2:0] OpZero    = 3'd5;

  typedef enum logic [2:0] {
    StZero,
    StIdle,
    StCruise,
    StCharge,
    StJump,
    StCool
  } state_e;

  state_e           state_q, state_d, rest_state;
  logic [3:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [k-1:0]     jpos_q, jpos_d;
  logic             err_d, done_d;
  logic [3:0]       mode_d, pos_mode_d;
  logic             busy_d, ready_d;

  // Where a finished or aborted jump lands: back to cruising if a speed is selected.
  assign rest_state = (speed_q != ModeStop) ? StCruise : StIdle;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    jpos_d  = jpos_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StZero: begin
        // A zero counter marks the extra ZERO cycle held after reset release.
        if (cnt_q == CntZero) begin
          cnt_d = CntOne;
        end else begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end
      end
      StIdle, StCruise: begin
        if (cmd_valid) begin
          case (cmd)
            OpHalt: begin
              state_d = StIdle;
              speed_d = ModeStop;
            end
            OpAttack: begin
              state_d = StCruise;
              speed_d = ModeAttack;
            end
            OpDefense: begin
              state_d = StCruise;
              speed_d = ModeDefense;
            end
            OpStealth: begin
              state_d = StCruise;
              speed_d = ModeStealth;
            end
            OpZero: begin
              state_d = StZero;
              speed_d = ModeStop;
              cnt_d   = CntOne;
            end
            OpJump: begin
              jpos_d = jump_target;
              if (CHARGE_CYCLES == 0) begin
                state_d = StJump;
              end else begin
                state_d = StCharge;
                cnt_d   = ChargeInit;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StCharge: begin
        if (abort) begin
          state_d = rest_state;
          cnt_d   = CntZero;
        end else if (cnt_q <= CntOne) begin
          state_d = StJump;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StJump: begin
        done_d = 1'b1;
        if (COOLDOWN_CYCLES == 0) begin
          state_d = rest_state;
        end else begin
          state_d = StCool;
          cnt_d   = CoolInit;
        end
      end
      StCool: begin
        if (cnt_q <= CntOne) begin
          state_d = rest_state;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StZero;
        cnt_d   = CntZero;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are valid right after each edge.
  always_comb begin
    mode_d     = (state_d == StCruise) ? speed_d : ModeStop;
    pos_mode_d = PosSub;
    if (state_d == StZero) begin
      pos_mode_d = PosZero;
    end else if (state_d == StJump) begin
      pos_mode_d = PosJump;
    end
    busy_d  = (state_d == StCharge) || (state_d == StJump) || (state_d == StCool);
    ready_d = (state_d == StIdle) || (state_d == StCruise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StZero;
      speed_q   <= ModeStop;
      cnt_q     <= CntZero;
      jpos_q    <= '0;
      mode      <= ModeStop;
      pos_mode  <= PosZero;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      jump_done <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      jpos_q    <= jpos_d;
      mode      <= mode_d;
      pos_mode  <= pos_mode_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      jump_done <= done_d;
      cmd_err   <= err_d;
    end
  end

  assign jump_position = jpos_q;

endmodule
